seq_detector_param: RTL

SEQ_DETECTOR_PARAM -- requirements
Module: seq_detector_param

---
 rtl/seq_detector_param.sv | 78 +++++++
 1 files changed

// File: rtl/seq_detector_param.sv
// rtl/seq_detector_param.sv - parameterised serial pattern detector with optional match counter
// Define SEQ_DET_COUNT_EN to build match_count/count_sat; otherwise both are tied to 0.
module seq_detector_param #(
   parameter int                 PAT_LEN = 4,
   parameter logic [PAT_LEN-1:0] PATTERN = 4'b1101,
   parameter int                 OVERLAP = 1,
   parameter int                 CNT_W   = 8
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             i,
   input  logic             in_valid,
   output logic             out,
   output logic [CNT_W-1:0] match_count,
   output logic             count_sat
);

   localparam int FILL_W = $clog2(PAT_LEN + 1);

   typedef enum logic {
      FILLING,
      ARMED
   } state_t;

   state_t              state;
   logic [PAT_LEN-1:0]  hist;
   logic [PAT_LEN-1:0]  hist_nxt;
   logic [FILL_W-1:0]   fill;
   logic                hit;

   // A hit needs a full window: already armed, or this bit completes the fill.
   always_comb begin
      hist_nxt = {hist[PAT_LEN-2:0], i};
      hit      = in_valid && (hist_nxt == PATTERN) &&
                 ((state == ARMED) || (fill == FILL_W'(PAT_LEN - 1)));
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state <= FILLING;
         hist  <= '0;
         fill  <= '0;
         out   <= 1'b0;
      end else begin
         out <= hit;
         if (in_valid) begin
            hist <= hist_nxt;
            if (hit && (OVERLAP == 0)) begin
               fill  <= '0;
               state <= FILLING;
            end else if (state == FILLING) begin
               fill  <= fill + FILL_W'(1);
               state <= (fill == FILL_W'(PAT_LEN - 1)) ? ARMED : FILLING;
            end
         end
      end
   end

`ifdef SEQ_DET_COUNT_EN
   // Counter holds at all-ones; a hit arriving at the ceiling raises the sticky flag.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         match_count <= '0;
         count_sat   <= 1'b0;
      end else if (hit) begin
         if (&match_count) begin
            count_sat <= 1'b1;
         end else begin
            match_count <= match_count + CNT_W'(1);
         end
      end
   end
`else
   assign match_count = '0;
   assign count_sat   = 1'b0;
`endif

endmodule
